multicycle_control_fsm: RTL

- Main control state machine of the multicycle RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath mux selects and write enables, including RegWrite, which is the register file's WE3.
- Sits between the instruction register (opcode source) and the datapath.
- Companion combinational ALU decoder consumes ALUOp (outside this block).

---
 rtl/multicycle_control_fsm.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath. Sequences each instruction
// through fetch, decode, execute, memory and writeback, and drives the datapath
// mux selects and write enables. Outputs are Moore-decoded from the state,
// except IllegalOp, which also depends on the opcode seen in Decode.
module multicycle_control_fsm #(
  parameter int unsigned OP_WIDTH    = 7,
  parameter int unsigned STATE_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [OP_WIDTH-1:0]    op,
  output logic                   PCUpdate,
  output logic                   Branch,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   AdrSrc,
  output logic [1:0]             ResultSrc,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic                   IllegalOp,
  output logic [STATE_WIDTH-1:0] State
);

  typedef enum logic [STATE_WIDTH-1:0] {
    StFetch,     // 0
    StDecode,    // 1
    StMemAdr,    // 2
    StMemRead,   // 3
    StMemWb,     // 4
    StMemWrite,  // 5
    StExecuteR,  // 6
    StAluWb,     // 7
    StExecuteI,  // 8
    StJal,       // 9
    StBeq        // 10
  } state_e;

  localparam logic [OP_WIDTH-1:0] OpLw   = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OpSw   = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OpR    = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OpI    = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OpJal  = OP_WIDTH'(7'b1101111);
  localparam logic [OP_WIDTH-1:0] OpBeq  = OP_WIDTH'(7'b1100011);

  state_e r_state;
  state_e w_next_state;
  logic   w_illegal;

  // State register with synchronous active-low reset back to Fetch.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; flags an unsupported opcode while in Decode.
  always_comb begin
    w_next_state = StFetch;
    w_illegal    = 1'b0;
    case (r_state)
      StFetch:    w_next_state = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw: w_next_state = StMemAdr;
          OpR:        w_next_state = StExecuteR;
          OpI:        w_next_state = StExecuteI;
          OpJal:      w_next_state = StJal;
          OpBeq:      w_next_state = StBeq;
          default: begin
            w_next_state = StFetch;
            w_illegal    = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        // op is held stable through MemAdr; anything unexpected returns to Fetch.
        if (op == OpLw) begin
          w_next_state = StMemRead;
        end else if (op == OpSw) begin
          w_next_state = StMemWrite;
        end else begin
          w_next_state = StFetch;
        end
      end
      StMemRead:  w_next_state = StMemWb;
      StMemWb:    w_next_state = StFetch;
      StMemWrite: w_next_state = StFetch;
      StExecuteR: w_next_state = StAluWb;
      StAluWb:    w_next_state = StFetch;
      StExecuteI: w_next_state = StAluWb;
      StJal:      w_next_state = StAluWb;
      StBeq:      w_next_state = StFetch;
      default:    w_next_state = StFetch;
    endcase
  end

  // Moore output decode; enables are gated off while reset is held low.
  always_comb begin
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (r_state)
      StFetch: begin
        IRWrite   = 1'b1;
        PCUpdate  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        RegWrite = 1'b1;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StJal: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      StBeq: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      default: ;
    endcase
    if (!RST) begin
      PCUpdate = 1'b0;
      Branch   = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  assign IllegalOp = w_illegal & RST;
  assign State     = r_state;

endmodule
